// File: rtl/main_control_fsm.sv
// Multicycle main control unit: sequences fetch/decode/execute/memory/writeback
// for the 8-bit processor and drives every datapath strobe.
module main_control_fsm #(
  parameter int OPW = 4,
  parameter int FNW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        alu_src_b,
  output logic [1:0]  Op,
  output logic [3:0]  func,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_LD   = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(3);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(4);
  localparam logic [OPW-1:0] OP_HALT = '1;

  state_t         cur, nxt;
  logic [OPW-1:0] opc;
  logic [FNW-1:0] fn;
  logic           is_r, is_ld, is_st, is_beq, is_jmp, is_halt, is_ill;
  logic           unused_instr_bits;

  assign unused_instr_bits = ^instr[15-OPW:FNW];

  assign is_r    = (opc == OP_R);
  assign is_ld   = (opc == OP_LD);
  assign is_st   = (opc == OP_ST);
  assign is_beq  = (opc == OP_BEQ);
  assign is_jmp  = (opc == OP_JMP);
  assign is_halt = (opc == OP_HALT);
  assign is_ill  = !(is_r || is_ld || is_st || is_beq || is_jmp || is_halt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      opc <= '0;
      fn  <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && mem_ready) begin
        opc <= instr[15 -: OPW];
        fn  <= instr[FNW-1:0];
      end
    end
  end

  always_comb begin
    nxt       = cur;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    alu_src_b = 1'b0;
    Op        = 2'b00;
    func      = 4'b0000;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    state     = cur;
    case (cur)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end
      end
      DECODE: begin
        if (is_jmp) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          nxt      = FETCH;
        end else if (is_halt) begin
          nxt = HALT;
        end else if (is_ill) begin
          illegal = 1'b1;
          nxt     = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (is_r) begin
          Op   = 2'b10;
          func = 4'(fn);
          nxt  = WB;
        end else if (is_ld || is_st) begin
          alu_src_b = 1'b1;
          nxt       = MEM;
        end else begin
          Op = 2'b01;
          if (zero) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
          nxt = FETCH;
        end
      end
      MEM: begin
        alu_src_b = 1'b1;
        addr_sel  = 1'b1;
        mem_read  = is_ld;
        mem_write = is_st;
        if (mem_ready) nxt = is_ld ? WB : FETCH;
      end
      WB: begin
        reg_write = 1'b1;
        if (is_r) begin
          Op   = 2'b10;
          func = 4'(fn);
        end else begin
          wb_sel = 1'b1;
        end
        nxt = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    // Reset masks every output combinationally, so strobes are low in the reset cycle itself
    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = 1'b0;
      alu_src_b = 1'b0;
      Op        = 2'b00;
      func      = 4'b0000;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      state     = 3'd0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench for main_control_fsm: each instruction is modelled as a
// micro-program string of phases, checked every cycle against the DUT.
module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        ir_write, pc_write, mem_read, mem_write, addr_sel, alu_src_b;
  logic        reg_write, wb_sel, halted, illegal;
  logic [1:0]  pc_src, Op;
  logic [3:0]  func;
  logic [2:0]  state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_cyc   = 0;

  string       prog = "F";
  int          idx  = 0;
  logic [3:0]  mop  = '0;
  logic [3:0]  mfn  = '0;

  main_control_fsm #(.OPW(4), .FNW(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .alu_src_b(alu_src_b), .Op(Op), .func(func), .reg_write(reg_write),
    .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  function automatic string prog_of(input logic [3:0] op);
    case (op)
      4'h0:    return "FDEW";
      4'h1:    return "FDEMW";
      4'h2:    return "FDEM";
      4'h3:    return "FDE";
      4'h4:    return "FD";
      4'hF:    return "FDH";
      default: return "FD";
    endcase
  endfunction

  // Packed order: ir_write pc_write pc_src mem_read mem_write addr_sel alu_src_b Op func reg_write wb_sel halted illegal state
  function automatic logic [31:0] expect_out(input byte ph, input logic [3:0] op, input logic [3:0] fn,
                                             input logic mr, input logic z, input logic r);
    logic irw = 0, pcw = 0, mrd = 0, mwr = 0, asel = 0, bsel = 0, rw = 0, wbs = 0, hlt = 0, ill = 0;
    logic [1:0] psrc = 0, aop = 0;
    logic [3:0] f = 0;
    logic [2:0] st = 0;
    bit legal = (op <= 4'h4) || (op == 4'hF);
    if (r) return 32'd0;
    case (ph)
      "F": begin st = 0; mrd = 1; if (mr) begin irw = 1; pcw = 1; end end
      "D": begin
        st = 1;
        if (op == 4'h4) begin pcw = 1; psrc = 2'b10; end
        if (!legal) ill = 1;
      end
      "E": begin
        st = 2;
        if (op == 4'h0) begin aop = 2'b10; f = fn; end
        else if (op == 4'h1 || op == 4'h2) bsel = 1;
        else begin aop = 2'b01; if (z) begin pcw = 1; psrc = 2'b01; end end
      end
      "M": begin st = 3; bsel = 1; asel = 1; mrd = (op == 4'h1); mwr = (op == 4'h2); end
      "W": begin st = 4; rw = 1; if (op == 4'h0) begin aop = 2'b10; f = fn; end else wbs = 1; end
      "H": begin st = 5; hlt = 1; end
      default: st = 0;
    endcase
    return {11'd0, irw, pcw, psrc, mrd, mwr, asel, bsel, aop, f, rw, wbs, hlt, ill, st};
  endfunction

  task automatic cycle(input logic r, input logic mr, input logic z, input logic [15:0] ins);
    byte ph;
    rst = r; mem_ready = mr; zero = z; instr = ins;
    #4;
    ph = prog[idx];
    check($sformatf("cyc%0d_%s", n_cyc, string'(ph)),
          {11'd0, ir_write, pc_write, pc_src, mem_read, mem_write, addr_sel, alu_src_b,
           Op, func, reg_write, wb_sel, halted, illegal, state},
          expect_out(ph, mop, mfn, mr, z, r));
    @(posedge clk);
    n_cyc++;
    if (r) begin
      prog = "F"; idx = 0; mop = '0; mfn = '0;
    end else if (ph == "H" || ((ph == "F" || ph == "M") && !mr)) begin
      // waiting or halted: no progress
    end else if (ph == "F") begin
      mop = ins[15:12]; mfn = ins[3:0]; prog = prog_of(mop); idx = 1;
    end else begin
      idx++;
      if (idx >= prog.len()) begin prog = "F"; idx = 0; end
    end
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    int unsigned k = $urandom_range(0, 19);
    if (k < 4)       op = 4'h0;
    else if (k < 7)  op = 4'h1;
    else if (k < 10) op = 4'h2;
    else if (k < 13) op = 4'h3;
    else if (k < 16) op = 4'h4;
    else if (k < 17) op = 4'hF;
    else             op = 4'(5 + $urandom_range(0, 9));
    return {op, 8'($urandom), 4'($urandom)};
  endfunction

  initial begin
    int unsigned hcnt = 0;
    cycle(1, 0, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    // R-type AND
    cycle(0, 1, 0, 16'h0007); repeat (3) cycle(0, 1, 0, 16'h0000);
    // LOAD with two MEM wait cycles
    cycle(0, 1, 0, 16'h1234); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    // BEQ taken then not taken
    cycle(0, 1, 1, 16'h3abc); cycle(0, 1, 1, 0); cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 16'h3abc); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    // JMP, illegal, HALT with mem_ready toggling
    cycle(0, 1, 0, 16'h4000); cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 16'h9000); cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 16'hF000); cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1'(i), 0, 16'h0000);
    // reset out of HALT, then STORE interrupted by reset mid-wait
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 16'h2000); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 16'h0007); repeat (3) cycle(0, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r;
      hcnt = (prog[idx] == "H") ? hcnt + 1 : 0;
      r = (hcnt > 12) || ($urandom_range(0, 59) == 0);
      cycle(r, $urandom_range(0, 9) < 7, 1'($urandom), rand_instr());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
